csi_lane_distributor: RTL and testbench

- Upstream feeder of the D-PHY master adapter layer.
- Accepts a CSI-2 packet as a byte stream and distributes consecutive bytes round-robin across N_DATA_LANES (byte k goes to lane k mod N).
- Pads the tail to a lane-word boundary, buffers the whole packet, then raises the HS transmit request with the burst size.
- The adapter pops one lane-word (N bytes) per hs_tx_word_clk until the burst is drained.

---
 rtl/csi_lane_distributor.sv | 256 +++++++++++++++++++++++++
 tb/tb_csi_lane_distributor.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/csi_lane_distributor.sv
// CSI-2 byte stream to N-lane word distributor feeding the D-PHY master adapter.
// Optional packet/pad statistics are enabled with `define CSI_LANE_DIST_STATS_EN.
module csi_lane_distributor #(
  parameter int N_DATA_LANES         = 4,
  parameter int HS_TX_WORD_BIT_WIDTH = 8,
  parameter int FIFO_DEPTH           = 64,
  parameter logic [HS_TX_WORD_BIT_WIDTH-1:0] PAD_BYTE = 8'h00
) (
  input  logic                                         hs_tx_word_clk,
  input  logic                                         rst,
  input  logic [HS_TX_WORD_BIT_WIDTH-1:0]              s_data,
  input  logic                                         s_valid,
  output logic                                         s_ready,
  input  logic                                         s_sop,
  input  logic                                         s_eop,
  output logic                                         tx_request_hs,
  output logic [15:0]                                  burst_size,
  input  logic                                         pop_en,
  output logic [N_DATA_LANES*HS_TX_WORD_BIT_WIDTH-1:0] pop_data,
  output logic                                         err_oversize,
  output logic                                         err_framing,
  output logic                                         err_underflow,
  input  logic                                         clear_err,
  output logic [15:0]                                  pkt_cnt,
  output logic [15:0]                                  pad_cnt
);

  localparam int W  = HS_TX_WORD_BIT_WIDTH;
  localparam int LW = N_DATA_LANES * W;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = (N_DATA_LANES > 1) ? $clog2(N_DATA_LANES) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(N_DATA_LANES - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_DROP = 2'd2,
    S_REQ  = 2'd3
  } state_t;

  state_t          state_r, state_n;
  logic [IW-1:0]   idx_r, idx_n, idx_eff_s;
  logic [LW-1:0]   asm_r, word_s, head_s;
  logic [LW-1:0]   mem_r [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_r, rd_ptr_r, wr_addr_s, wr_ptr_n, rd_base_s, rd_ptr_n;
  logic [CW-1:0]   count_r, count_n, cnt_base_s, cnt_mid_s;
  logic [15:0]     burst_s;
  logic            acc_s, start_s, beat_s, flush_s, push_s, pop_s, go_req_s;
  logic            set_framing_s, set_oversize_s, set_underflow_s;
  logic            s_ready_r, tx_request_hs_r;
  logic [15:0]     burst_size_r;
  logic [LW-1:0]   pop_data_r;
  logic            err_oversize_r, err_framing_r, err_underflow_r;

  assign acc_s           = s_valid && s_ready_r;
  assign set_underflow_s = pop_en && !pop_s;
  assign burst_s         = 16'((32'(cnt_base_s) + 32'd1) * 32'(N_DATA_LANES));

  // Next-state and beat/pop decode; a start beat always lands in lane 0 of an empty FIFO.
  always_comb begin
    state_n        = state_r;
    idx_n          = idx_r;
    start_s        = 1'b0;
    beat_s         = 1'b0;
    flush_s        = 1'b0;
    push_s         = 1'b0;
    pop_s          = 1'b0;
    go_req_s       = 1'b0;
    set_framing_s  = 1'b0;
    set_oversize_s = 1'b0;
    word_s         = '0;
    case (state_r)
      S_IDLE: begin
        if (acc_s && s_sop) begin
          start_s = 1'b1;
        end else if (acc_s) begin
          set_framing_s = 1'b1;
        end else begin
          start_s = 1'b0;
        end
      end
      S_FILL: begin
        if (acc_s && s_sop) begin
          start_s       = 1'b1;
          flush_s       = 1'b1;
          set_framing_s = 1'b1;
        end else if (acc_s && (count_r == DEPTH_C)) begin
          set_oversize_s = 1'b1;
          flush_s        = 1'b1;
          idx_n          = '0;
          state_n        = s_eop ? S_IDLE : S_DROP;
        end else if (acc_s) begin
          beat_s = 1'b1;
        end else begin
          beat_s = 1'b0;
        end
      end
      S_DROP: begin
        if (acc_s && s_eop) begin
          state_n = S_IDLE;
        end else begin
          state_n = S_DROP;
        end
      end
      S_REQ: begin
        if (pop_en && (count_r != '0)) begin
          pop_s   = 1'b1;
          state_n = (count_r == CW'(1)) ? S_IDLE : S_REQ;
        end else begin
          pop_s = 1'b0;
        end
      end
      default: state_n = S_IDLE;
    endcase

    if (start_s) begin
      idx_eff_s  = '0;
      cnt_base_s = '0;
    end else begin
      idx_eff_s  = idx_r;
      cnt_base_s = count_r;
    end

    // Lanes below idx keep assembled bytes, lanes above it carry the pad value.
    for (int i = 0; i < N_DATA_LANES; i++) begin
      if (i == int'(idx_eff_s)) begin
        word_s[i*W +: W] = s_data;
      end else if (i < int'(idx_eff_s)) begin
        word_s[i*W +: W] = asm_r[i*W +: W];
      end else begin
        word_s[i*W +: W] = PAD_BYTE;
      end
    end

    if (start_s || beat_s) begin
      if (s_eop) begin
        push_s   = 1'b1;
        go_req_s = 1'b1;
        idx_n    = '0;
        state_n  = S_REQ;
      end else if (idx_eff_s == IDX_LAST) begin
        push_s  = 1'b1;
        idx_n   = '0;
        state_n = S_FILL;
      end else begin
        idx_n   = idx_eff_s + IW'(1);
        state_n = S_FILL;
      end
    end else begin
      go_req_s = 1'b0;
    end
  end

  // FIFO pointer/occupancy update and next show-ahead head word.
  always_comb begin
    if (flush_s) begin
      wr_addr_s = '0;
      rd_base_s = '0;
      cnt_mid_s = '0;
    end else begin
      wr_addr_s = wr_ptr_r;
      rd_base_s = rd_ptr_r;
      cnt_mid_s = count_r;
    end
    if (push_s) begin
      wr_ptr_n = wr_addr_s + AW'(1);
    end else begin
      wr_ptr_n = wr_addr_s;
    end
    if (pop_s) begin
      rd_ptr_n = rd_base_s + AW'(1);
    end else begin
      rd_ptr_n = rd_base_s;
    end
    count_n = cnt_mid_s + (push_s ? CW'(1) : CW'(0)) - (pop_s ? CW'(1) : CW'(0));
    if (count_n == '0) begin
      head_s = '0;
    end else if (push_s && (wr_addr_s == rd_ptr_n)) begin
      head_s = word_s;
    end else begin
      head_s = mem_r[rd_ptr_n];
    end
  end

  // Lane-word storage; contents are don't-care until pushed.
  always_ff @(posedge hs_tx_word_clk) begin
    if (!rst && push_s) begin
      mem_r[wr_addr_s] <= word_s;
    end
  end

  // State, FIFO bookkeeping, registered outputs and sticky errors.
  always_ff @(posedge hs_tx_word_clk) begin
    if (rst) begin
      state_r         <= S_IDLE;
      idx_r           <= '0;
      asm_r           <= '0;
      wr_ptr_r        <= '0;
      rd_ptr_r        <= '0;
      count_r         <= '0;
      s_ready_r       <= 1'b0;
      tx_request_hs_r <= 1'b0;
      burst_size_r    <= 16'd0;
      pop_data_r      <= '0;
      err_oversize_r  <= 1'b0;
      err_framing_r   <= 1'b0;
      err_underflow_r <= 1'b0;
    end else begin
      state_r         <= state_n;
      idx_r           <= idx_n;
      wr_ptr_r        <= wr_ptr_n;
      rd_ptr_r        <= rd_ptr_n;
      count_r         <= count_n;
      pop_data_r      <= head_s;
      s_ready_r       <= (state_n != S_REQ);
      tx_request_hs_r <= (state_n == S_REQ);
      asm_r           <= (start_s || beat_s) ? word_s : asm_r;
      burst_size_r    <= go_req_s ? burst_s : burst_size_r;
      err_oversize_r  <= set_oversize_s  ? 1'b1 : (clear_err ? 1'b0 : err_oversize_r);
      err_framing_r   <= set_framing_s   ? 1'b1 : (clear_err ? 1'b0 : err_framing_r);
      err_underflow_r <= set_underflow_s ? 1'b1 : (clear_err ? 1'b0 : err_underflow_r);
    end
  end

  assign s_ready       = s_ready_r;
  assign tx_request_hs = tx_request_hs_r;
  assign burst_size    = burst_size_r;
  assign pop_data      = pop_data_r;
  assign err_oversize  = err_oversize_r;
  assign err_framing   = err_framing_r;
  assign err_underflow = err_underflow_r;

`ifdef CSI_LANE_DIST_STATS_EN
  logic [15:0] pkt_cnt_r, pad_cnt_r;

  // Burst completions and pad bytes inserted at padded end-of-packet.
  always_ff @(posedge hs_tx_word_clk) begin
    if (rst) begin
      pkt_cnt_r <= 16'd0;
      pad_cnt_r <= 16'd0;
    end else begin
      pkt_cnt_r <= ((state_r == S_REQ) && (state_n == S_IDLE)) ? pkt_cnt_r + 16'd1 : pkt_cnt_r;
      pad_cnt_r <= go_req_s ? pad_cnt_r + 16'(IDX_LAST - idx_eff_s) : pad_cnt_r;
    end
  end

  assign pkt_cnt = pkt_cnt_r;
  assign pad_cnt = pad_cnt_r;
`else
  assign pkt_cnt = 16'd0;
  assign pad_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_csi_lane_distributor.sv
// Directed bench for csi_lane_distributor: packet table plus hand-written error/reset sequences.
module tb_csi_lane_distributor;

  logic        clk;
  logic        rst;
  logic [7:0]  s_data;
  logic        s_valid, s_ready, s_sop, s_eop;
  logic        tx_request_hs;
  logic [15:0] burst_size;
  logic        pop_en;
  logic [31:0] pop_data;
  logic        err_oversize, err_framing, err_underflow, clear_err;
  logic [15:0] pkt_cnt, pad_cnt;

  int n_err = 0;
  int n_chk = 0;
  int exp_pkt = 0;
  int exp_pad = 0;

  typedef struct packed {
    logic [7:0]       len;
    logic [7:0]       base;
    logic [15:0]      burst;
    logic [3:0][31:0] words;
    logic [7:0]       pad;
  } vec_t;

  vec_t vecs [6];

  csi_lane_distributor #(
    .N_DATA_LANES(4),
    .HS_TX_WORD_BIT_WIDTH(8),
    .FIFO_DEPTH(4),
    .PAD_BYTE(8'h00)
  ) dut (
    .hs_tx_word_clk(clk),
    .rst(rst),
    .s_data(s_data),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_sop(s_sop),
    .s_eop(s_eop),
    .tx_request_hs(tx_request_hs),
    .burst_size(burst_size),
    .pop_en(pop_en),
    .pop_data(pop_data),
    .err_oversize(err_oversize),
    .err_framing(err_framing),
    .err_underflow(err_underflow),
    .clear_err(clear_err),
    .pkt_cnt(pkt_cnt),
    .pad_cnt(pad_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] d, input logic sop, input logic eop);
    s_data  = d;
    s_valid = 1'b1;
    s_sop   = sop;
    s_eop   = eop;
    tick();
    s_valid = 1'b0;
    s_sop   = 1'b0;
    s_eop   = 1'b0;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (s_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("s_ready_before_pkt", 32'(s_ready), 32'd1);
  endtask

  task automatic send(input int len, input logic [7:0] base);
    wait_ready();
    for (int k = 0; k < len; k++) begin
      beat(8'(int'(base) + k), (k == 0), (k == len - 1));
    end
  endtask

  task automatic check_stats();
`ifdef CSI_LANE_DIST_STATS_EN
    chk("pkt_cnt", 32'(pkt_cnt), 32'(exp_pkt));
    chk("pad_cnt", 32'(pad_cnt), 32'(exp_pad));
`else
    chk("pkt_cnt_tied", 32'(pkt_cnt), 32'd0);
    chk("pad_cnt_tied", 32'(pad_cnt), 32'd0);
`endif
  endtask

  // Expects the packet to be fully accepted already; drains and checks it.
  task automatic drain(input vec_t v);
    int nw;
    chk("tx_req_after_eop", 32'(tx_request_hs), 32'd1);
    chk("s_ready_in_req", 32'(s_ready), 32'd0);
    chk("burst_size", 32'(burst_size), 32'(v.burst));
    exp_pad += int'(v.pad);
    nw = int'(v.burst) / 4;
    for (int w = 0; w < nw; w++) begin
      chk("pop_data", pop_data, v.words[w]);
      chk("tx_req_held", 32'(tx_request_hs), 32'd1);
      pop_en = 1'b1;
      tick();
      pop_en = 1'b0;
    end
    exp_pkt++;
    chk("tx_req_dropped", 32'(tx_request_hs), 32'd0);
    chk("s_ready_after_burst", 32'(s_ready), 32'd1);
    check_stats();
  endtask

  initial begin
    int seen_req;
    vec_t vr;

    vecs[0] = '{len: 8'd8,  base: 8'h00, burst: 16'd8,
                words: {32'h0, 32'h0, 32'h07060504, 32'h03020100}, pad: 8'd0};
    vecs[1] = '{len: 8'd5,  base: 8'hA0, burst: 16'd8,
                words: {32'h0, 32'h0, 32'h000000A4, 32'hA3A2A1A0}, pad: 8'd3};
    vecs[2] = '{len: 8'd1,  base: 8'h5A, burst: 16'd4,
                words: {32'h0, 32'h0, 32'h0, 32'h0000005A}, pad: 8'd3};
    vecs[3] = '{len: 8'd3,  base: 8'h10, burst: 16'd4,
                words: {32'h0, 32'h0, 32'h0, 32'h00121110}, pad: 8'd1};
    vecs[4] = '{len: 8'd16, base: 8'h40, burst: 16'd16,
                words: {32'h4F4E4D4C, 32'h4B4A4948, 32'h47464544, 32'h43424140}, pad: 8'd0};
    vecs[5] = '{len: 8'd6,  base: 8'hC0, burst: 16'd8,
                words: {32'h0, 32'h0, 32'h0000C5C4, 32'hC3C2C1C0}, pad: 8'd2};

    rst = 1'b1; s_data = 8'h00; s_valid = 1'b0; s_sop = 1'b0; s_eop = 1'b0;
    pop_en = 1'b0; clear_err = 1'b0;
    tick();
    tick();
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_tx_req", 32'(tx_request_hs), 32'd0);
    chk("rst_burst", 32'(burst_size), 32'd0);
    chk("rst_pop_data", pop_data, 32'd0);
    chk("rst_err_ov", 32'(err_oversize), 32'd0);
    chk("rst_err_fr", 32'(err_framing), 32'd0);
    chk("rst_err_un", 32'(err_underflow), 32'd0);
    chk("rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
    chk("rst_pad_cnt", 32'(pad_cnt), 32'd0);
    rst = 1'b0;
    tick();
    chk("s_ready_after_rst", 32'(s_ready), 32'd1);

    for (int i = 0; i < 6; i++) begin
      send(int'(vecs[i].len), vecs[i].base);
      drain(vecs[i]);
    end
    chk("no_err_after_table", 32'({err_oversize, err_framing, err_underflow}), 32'd0);

    // Underflow while idle, then clear racing a fresh error, then a plain clear.
    pop_en = 1'b1;
    tick();
    pop_en = 1'b0;
    chk("underflow_set", 32'(err_underflow), 32'd1);
    chk("underflow_no_req", 32'(tx_request_hs), 32'd0);
    clear_err = 1'b1; pop_en = 1'b1;
    tick();
    chk("error_beats_clear", 32'(err_underflow), 32'd1);
    pop_en = 1'b0;
    tick();
    clear_err = 1'b0;
    chk("underflow_cleared", 32'(err_underflow), 32'd0);

    // Beat without sop while idle is dropped.
    beat(8'h33, 1'b0, 1'b0);
    chk("framing_idle", 32'(err_framing), 32'd1);
    chk("framing_idle_no_req", 32'(tx_request_hs), 32'd0);
    clear_err = 1'b1; tick(); clear_err = 1'b0;
    chk("framing_cleared", 32'(err_framing), 32'd0);

    // sop inside an open packet restarts with that byte in lane 0.
    beat(8'h70, 1'b1, 1'b0);
    beat(8'h71, 1'b0, 1'b0);
    beat(8'h72, 1'b0, 1'b0);
    chk("no_framing_yet", 32'(err_framing), 32'd0);
    send(5, 8'h80);
    chk("framing_restart", 32'(err_framing), 32'd1);
    vr = '{len: 8'd5, base: 8'h80, burst: 16'd8,
           words: {32'h0, 32'h0, 32'h00000084, 32'h83828180}, pad: 8'd3};
    drain(vr);
    clear_err = 1'b1; tick(); clear_err = 1'b0;

    // 20-byte packet into a 4-word FIFO: oversize on the 17th byte, rest dropped.
    wait_ready();
    seen_req = 0;
    for (int k = 0; k < 20; k++) begin
      beat(8'(32'h20 + k), (k == 0), (k == 19));
      if (tx_request_hs) seen_req++;
      if (k == 15) chk("oversize_not_yet", 32'(err_oversize), 32'd0);
      if (k == 16) chk("oversize_set", 32'(err_oversize), 32'd1);
      if (k > 16) chk("drop_s_ready", 32'(s_ready), 32'd1);
    end
    tick();
    if (tx_request_hs) seen_req++;
    chk("oversize_no_req", 32'(seen_req), 32'd0);
    chk("oversize_flushed", pop_data, 32'd0);
    chk("oversize_no_framing", 32'(err_framing), 32'd0);
    clear_err = 1'b1; tick(); clear_err = 1'b0;
    send(int'(vecs[1].len), vecs[1].base);
    drain(vecs[1]);

    // Reset in the middle of a burst discards buffered data.
    send(int'(vecs[0].len), vecs[0].base);
    chk("mid_req_active", 32'(tx_request_hs), 32'd1);
    pop_en = 1'b1; tick(); pop_en = 1'b0;
    chk("mid_req_second_word", pop_data, 32'h07060504);
    rst = 1'b1;
    tick();
    chk("mid_rst_tx_req", 32'(tx_request_hs), 32'd0);
    chk("mid_rst_pop_data", pop_data, 32'd0);
    chk("mid_rst_s_ready", 32'(s_ready), 32'd0);
    chk("mid_rst_burst", 32'(burst_size), 32'd0);
    rst = 1'b0;
    exp_pkt = 0;
    exp_pad = 0;
    tick();
    chk("s_ready_after_mid_rst", 32'(s_ready), 32'd1);
    check_stats();
    pop_en = 1'b1; tick(); pop_en = 1'b0;
    chk("fifo_empty_after_rst", 32'(err_underflow), 32'd1);
    chk("no_req_after_rst", 32'(tx_request_hs), 32'd0);
    clear_err = 1'b1; tick(); clear_err = 1'b0;
    send(int'(vecs[2].len), vecs[2].base);
    drain(vecs[2]);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
